// File: rtl/uart_dump_if.sv
// uart_dump_if: RIB master-port bundle used by uart_dump.
// Carries request, address, write data/enable and read data.
interface uart_dump_if;
    logic        req_o;
    logic        we_o;
    logic [31:0] addr_o;
    logic [31:0] wdata_o;
    logic [31:0] rdata_i;

    modport master (
        output req_o,
        output we_o,
        output addr_o,
        output wdata_o,
        input  rdata_i
    );

    modport slave (
        input  req_o,
        input  we_o,
        input  addr_o,
        input  wdata_o,
        output rdata_i
    );
endinterface

// File: rtl/uart_dump.sv
// uart_dump: reads a word range over RIB and streams it out as 8N1 UART.
// Optional trailing XOR checksum byte when UART_DUMP_CKSUM_EN is defined.
module uart_dump #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [31:0]        base_addr_i,
    input  logic [15:0]        word_cnt_i,
    output logic               busy_o,
    output logic               done_o,
    uart_dump_if.master        rib,
    output logic               tx_pin
);

    localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_TX,
        S_NEXT,
`ifdef UART_DUMP_CKSUM_EN
        S_CKSUM,
`endif
        S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] rem_q, rem_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  byte_q, byte_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] baud_q, baud_d;
`ifdef UART_DUMP_CKSUM_EN
    logic [7:0]  cksum_q, cksum_d;
`endif

    logic       tx_active;
    logic       bit_end;
    logic       frame_end;
    logic       last_byte;
    logic [7:0] tx_byte;
    logic [2:0] data_idx;

    assign bit_end   = (baud_q == 16'd0);
    assign frame_end = bit_end && (bit_q == 4'd9);
    assign last_byte = (byte_q == 2'd3);
    assign data_idx  = 3'(bit_q - 4'd1);

    // Shifter runs during data bytes and, if enabled, the checksum byte.
    always_comb begin
        tx_active = (state_q == S_TX);
        tx_byte   = word_q[{byte_q, 3'b000} +: 8];
`ifdef UART_DUMP_CKSUM_EN
        if (state_q == S_CKSUM) begin
            tx_active = 1'b1;
            tx_byte   = cksum_q;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the word advance happens at the last stop bit
    // so consecutive words follow without a gap cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (word_cnt_i == 16'd0) begin
                        state_d = S_NEXT;
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_RD_REQ:  state_d = S_RD_WAIT;
            S_RD_WAIT: state_d = S_TX;
            S_TX: begin
                if (frame_end && last_byte) begin
                    if (rem_q != 16'd1) begin
                        state_d = S_RD_REQ;
                    end else begin
`ifdef UART_DUMP_CKSUM_EN
                        state_d = S_CKSUM;
`else
                        state_d = S_FIN;
`endif
                    end
                end
            end
            S_NEXT: begin
                if (rem_q != 16'd0) begin
                    state_d = S_RD_REQ;
                end else begin
                    state_d = S_FIN;
                end
            end
`ifdef UART_DUMP_CKSUM_EN
            S_CKSUM: begin
                if (frame_end) begin
                    state_d = S_FIN;
                end
            end
`endif
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: address/count latch, word capture, bit timing.
    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        word_d = word_q;
        byte_d = byte_q;
        bit_d  = bit_q;
        baud_d = baud_q;
`ifdef UART_DUMP_CKSUM_EN
        cksum_d = cksum_q;
`endif
        if (state_q == S_IDLE && start_i) begin
            addr_d = base_addr_i & 32'hFFFF_FFFC;
            rem_d  = word_cnt_i;
`ifdef UART_DUMP_CKSUM_EN
            cksum_d = 8'h00;
`endif
        end
        if (state_q == S_RD_WAIT) begin
            word_d = rib.rdata_i;
            byte_d = 2'd0;
            bit_d  = 4'd0;
            baud_d = BAUD_RELOAD;
`ifdef UART_DUMP_CKSUM_EN
            cksum_d = cksum_q ^ rib.rdata_i[7:0] ^ rib.rdata_i[15:8]
                    ^ rib.rdata_i[23:16] ^ rib.rdata_i[31:24];
`endif
        end
        if (tx_active) begin
            if (bit_end) begin
                baud_d = BAUD_RELOAD;
                if (bit_q == 4'd9) begin
                    bit_d  = 4'd0;
                    byte_d = byte_q + 2'd1;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end else begin
                baud_d = baud_q - 16'd1;
            end
        end
        if (state_q == S_TX && frame_end && last_byte) begin
            addr_d = addr_q + 32'd4;
            rem_d  = rem_q - 16'd1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= 32'd0;
            rem_q  <= 16'd0;
            word_q <= 32'd0;
            byte_q <= 2'd0;
            bit_q  <= 4'd0;
            baud_q <= 16'd0;
`ifdef UART_DUMP_CKSUM_EN
            cksum_q <= 8'h00;
`endif
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
            word_q <= word_d;
            byte_q <= byte_d;
            bit_q  <= bit_d;
            baud_q <= baud_d;
`ifdef UART_DUMP_CKSUM_EN
            cksum_q <= cksum_d;
`endif
        end
    end

    // Outputs decoded from state; the line idles high outside a frame.
    always_comb begin
        busy_o       = (state_q != S_IDLE) && (state_q != S_FIN);
        done_o       = (state_q == S_FIN);
        rib.req_o    = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT);
        rib.we_o     = 1'b0;
        rib.addr_o   = addr_q;
        rib.wdata_o  = 32'd0;
        tx_pin       = 1'b1;
        if (tx_active) begin
            if (bit_q == 4'd0) begin
                tx_pin = 1'b0;
            end else if (bit_q == 4'd9) begin
                tx_pin = 1'b1;
            end else begin
                tx_pin = tx_byte[data_idx];
            end
        end
    end

endmodule

// File: tb/tb_uart_dump.sv
// tb_uart_dump: directed bench for uart_dump with BAUD_DIV=4.
// Decodes the TX line and watches the RIB port against hand-computed values.
module tb_uart_dump;

    localparam int BAUD = 4;
`ifdef UART_DUMP_CKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int WCYC = 2 + 40 * BAUD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] base_addr_i = 32'd0;
    logic [15:0] word_cnt_i = 16'd0;
    logic        busy_o;
    logic        done_o;
    logic        tx_pin;

    uart_dump_if bus();

    uart_dump #(.BAUD_DIV(BAUD)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .word_cnt_i  (word_cnt_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rib         (bus.master),
        .tx_pin      (tx_pin)
    );

    always #5 clk = ~clk;

    logic [31:0] m_addr [8];
    logic [31:0] m_data [8];

    always_comb begin
        bus.rdata_i = 32'hDEAD_BEEF;
        for (int i = 0; i < 8; i++) begin
            if (m_addr[i] == bus.addr_o) bus.rdata_i = m_data[i];
        end
    end

    int passed = 0;
    int total  = 0;

    int ncyc = 0;
    int t_start = 0;
    int t_done = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int req_cnt = 0;
    int rx_bad = 0;
    logic req_prev = 1'b0;
    logic [31:0] addr_q [$];
    logic [7:0]  rx_q [$];
    logic [7:0]  exp_q [$];

    always @(negedge clk) begin
        ncyc++;
        if (start_i && !busy_o && !done_o && !rst) t_start = ncyc;
        if (busy_o) busy_cnt++;
        if (done_o) begin
            t_done = ncyc;
            done_cnt++;
        end
        if (bus.req_o) begin
            req_cnt++;
            if (!req_prev) addr_q.push_back(bus.addr_o);
        end
        req_prev = bus.req_o;
    end

    initial begin : rx_mon
        logic [7:0] d;
        logic ok;
        d = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && tx_pin === 1'b0) begin
                ok = 1'b1;
                repeat (BAUD - 1) begin
                    @(negedge clk);
                    if (tx_pin !== 1'b0) ok = 1'b0;
                end
                for (int b = 0; b < 8; b++) begin
                    @(negedge clk);
                    d[b] = tx_pin;
                    repeat (BAUD - 1) begin
                        @(negedge clk);
                        if (tx_pin !== d[b]) ok = 1'b0;
                    end
                end
                repeat (BAUD) begin
                    @(negedge clk);
                    if (tx_pin !== 1'b1) ok = 1'b0;
                end
                rx_q.push_back(d);
                if (!ok) rx_bad++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clr();
        busy_cnt = 0;
        done_cnt = 0;
        req_cnt  = 0;
        rx_bad   = 0;
        addr_q.delete();
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] a, input logic [15:0] n);
        step();
        start_i = 1'b1;
        base_addr_i = a;
        word_cnt_i = n;
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int n;
        n = 0;
        while (done_cnt == 0 && n < max) begin
            step();
            n++;
        end
        check("done_seen", 32'(done_cnt), 32'd1);
        check("done_drop", {31'd0, done_o}, 32'd0);
        check("busy_drop", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
    endtask

    task automatic cmp_rx(input string tag);
        check({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_q.size()));
        check({tag, "_framing"}, 32'(rx_bad), 32'd0);
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), {24'd0, rx_q[i]},
                  {24'd0, exp_q[i]});
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_addr[i] = 32'h0000_1000 + 32'(i);
            m_data[i] = 32'h0;
        end
        m_addr[0] = 32'h0000_0100; m_data[0] = 32'h4433_2211;
        m_addr[1] = 32'h0000_0200; m_data[1] = 32'h0302_0100;
        m_addr[2] = 32'h0000_0204; m_data[2] = 32'h0706_0504;
        m_addr[3] = 32'h0000_0208; m_data[3] = 32'h0B0A_0908;
        m_addr[4] = 32'hFFFF_FFFC; m_data[4] = 32'hA1B2_C3D4;
        m_addr[5] = 32'h0000_0000; m_data[5] = 32'h5566_7788;
        m_addr[6] = 32'h0000_0400; m_data[6] = 32'h4433_2211;
        m_addr[7] = 32'h0000_0404; m_data[7] = 32'h0000_00FF;

        repeat (3) step();
        check("rst_tx", {31'd0, tx_pin}, 32'd1);
        check("rst_req", {31'd0, bus.req_o}, 32'd0);
        check("rst_addr", bus.addr_o, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_we", {31'd0, bus.we_o}, 32'd0);
        check("rst_wdata", bus.wdata_o, 32'd0);
        rst = 1'b0;
        repeat (2) step();

        clr();
        start(32'h100, 16'd1);
        check("w1_busy_e0", {31'd0, busy_o}, 32'd1);
        check("w1_req_e0", {31'd0, bus.req_o}, 32'd1);
        check("w1_addr_e0", bus.addr_o, 32'h100);
        step();
        check("w1_req_e1", {31'd0, bus.req_o}, 32'd1);
        check("w1_tx_e1", {31'd0, tx_pin}, 32'd1);
        step();
        check("w1_req_e2", {31'd0, bus.req_o}, 32'd0);
        check("w1_tx_e2", {31'd0, tx_pin}, 32'd0);
        wait_done(2000);
        check("w1_done_t", 32'(t_done - t_start), 32'(WCYC + 1 + CK * 40));
        check("w1_req_cycles", 32'(req_cnt), 32'd2);
        check("w1_busy_cycles", 32'(busy_cnt), 32'(WCYC + CK * 40));
        push_word(32'h4433_2211);
        if (CK != 0) exp_q.push_back(8'h44);
        cmp_rx("w1");

        repeat (3) step();
        clr();
        start(32'h203, 16'd3);
        repeat (200) step();
        start_i = 1'b1;
        base_addr_i = 32'h500;
        word_cnt_i = 16'd7;
        step();
        start_i = 1'b0;
        wait_done(4000);
        check("w3_nreq", 32'(addr_q.size()), 32'd3);
        if (addr_q.size() == 3) begin
            check("w3_addr0", addr_q[0], 32'h200);
            check("w3_addr1", addr_q[1], 32'h204);
            check("w3_addr2", addr_q[2], 32'h208);
        end
        check("w3_req_cycles", 32'(req_cnt), 32'd6);
        check("w3_busy_cycles", 32'(busy_cnt), 32'(3 * WCYC + CK * 40));
        check("w3_done_t", 32'(t_done - t_start), 32'(3 * WCYC + 1 + CK * 40));
        push_word(32'h0302_0100);
        push_word(32'h0706_0504);
        push_word(32'h0B0A_0908);
        if (CK != 0) exp_q.push_back(8'h00);
        cmp_rx("w3");

        repeat (3) step();
        clr();
        start(32'h300, 16'd0);
        check("z_busy_e0", {31'd0, busy_o}, 32'd1);
        check("z_done_e0", {31'd0, done_o}, 32'd0);
        check("z_tx_e0", {31'd0, tx_pin}, 32'd1);
        step();
        check("z_done_e1", {31'd0, done_o}, 32'd1);
        check("z_busy_e1", {31'd0, busy_o}, 32'd0);
        step();
        check("z_done_e2", {31'd0, done_o}, 32'd0);
        repeat (50) step();
        check("z_req_cycles", 32'(req_cnt), 32'd0);
        check("z_busy_cycles", 32'(busy_cnt), 32'd1);
        check("z_done_pulses", 32'(done_cnt), 32'd1);
        check("z_nbytes", 32'(rx_q.size()), 32'd0);

        clr();
        start(32'hFFFF_FFFC, 16'd2);
        wait_done(4000);
        check("wr_nreq", 32'(addr_q.size()), 32'd2);
        if (addr_q.size() == 2) begin
            check("wr_addr0", addr_q[0], 32'hFFFF_FFFC);
            check("wr_addr1", addr_q[1], 32'h0000_0000);
        end
        push_word(32'hA1B2_C3D4);
        push_word(32'h5566_7788);
        if (CK != 0) exp_q.push_back(8'hC8);
        cmp_rx("wr");

        repeat (3) step();
        clr();
        start(32'h100, 16'd1);
        repeat (55) @(posedge clk);
        #1;
        check("rm_tx_bit3", {31'd0, tx_pin}, 32'd0);
        rst = 1'b1;
        step();
        check("rm_tx", {31'd0, tx_pin}, 32'd1);
        check("rm_req", {31'd0, bus.req_o}, 32'd0);
        check("rm_busy", {31'd0, busy_o}, 32'd0);
        check("rm_done", {31'd0, done_o}, 32'd0);
        check("rm_addr", bus.addr_o, 32'd0);
        rst = 1'b0;
        repeat (60) step();
        check("rm_idle_tx", {31'd0, tx_pin}, 32'd1);
        clr();
        start(32'h100, 16'd1);
        wait_done(2000);
        check("rm_done_t", 32'(t_done - t_start), 32'(WCYC + 1 + CK * 40));
        push_word(32'h4433_2211);
        if (CK != 0) exp_q.push_back(8'h44);
        cmp_rx("rm");

        repeat (3) step();
        clr();
        start(32'h400, 16'd2);
        wait_done(4000);
        check("ck_done_t", 32'(t_done - t_start), 32'(2 * WCYC + 1 + CK * 40));
        push_word(32'h4433_2211);
        push_word(32'h0000_00FF);
        if (CK != 0) exp_q.push_back(8'hBB);
        cmp_rx("ck");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_dump.md
# uart_dump

Memory-dump transmitter for the RIB bus: the counterpart of the UART download path that writes memory from the serial port. On a start command it acts as a RIB master, reads a word-aligned range of memory and streams the bytes out of a UART TX pin (8N1, LSB first). It attaches to a free RIB master port and to a dedicated TX pin, and lets a host read back RAM or ROM contents without JTAG.

## Interface

- `BAUD_DIV`, default 434: clock cycles per UART bit (50 MHz / 115200). Legal range is 2..65535.
- `clk` in, 1: system clock; the only clock.
- `rst` in, 1: synchronous, active-high reset.
- `start_i` in, 1: one-cycle start command; ignored while `busy_o`=1.
- `base_addr_i` in, 32: byte address of the first word; bits [1:0] are forced to 0 at latch.
- `word_cnt_i` in, 16: number of 32-bit words to dump; latched together with `base_addr_i`.
- `busy_o` out, 1: high from the start command until the dump is complete.
- `done_o` out, 1: one-cycle pulse at completion.
- `req_o` out, 1: RIB request.
- `we_o` out, 1: RIB write enable; constant 0.
- `addr_o` out, 32: RIB address.
- `wdata_o` out, 32: RIB write data; constant 0.
- `rdata_i` in, 32: RIB read data.
- `tx_pin` out, 1: UART serial output; idles high.

## Operation

- **State machine:** IDLE, RD_REQ, RD_WAIT, TX, NEXT, plus CKSUM when the checksum feature is compiled in.
- **IDLE:** `start_i`=1 latches the base address and word count. If the count is 0, go straight to DONE handling. Otherwise go to RD_REQ.
- **RD_REQ:** `req_o`=1 and `addr_o`=current address, held for exactly 2 cycles (RD_REQ, then RD_WAIT).
  - At the end of RD_WAIT, `rdata_i` is captured into the word buffer.
  - `req_o` drops.
  - Go to TX with byte index 0.
- **TX:** sends bytes [7:0], [15:8], [23:16], [31:24] in that order (little-endian).
  - Each byte is framed as: start bit 0, data bits LSB first, stop bit 1.
  - Each bit lasts exactly `BAUD_DIV` cycles, set by a down-counter reloaded at `BAUD_DIV-1`.
  - A 4-bit bit index runs 0..9.
  - The next byte's start bit follows the previous stop bit with no idle gap.
- **NEXT:** address += 4, with wrap-around modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000). Remaining count -= 1. If the count is then nonzero, go to RD_REQ; if it is zero, finish.
- **Finish:** `done_o`=1 for 1 cycle and `busy_o`=0 in the same cycle; return to IDLE.
- **Counts:** the word count is 16 bits, so the maximum dump is 65535 words. The address counter is 32 bits.
- **Bus arbitration:** no bus grant exists. The bus arbiter's priority order must place this master such that its 2-cycle read is not interrupted. The block assumes `rdata_i` is valid in the second request cycle.

## Timing

- **Output reset values:** `tx_pin`=1, `req_o`=0, `addr_o`=0, `busy_o`=0, `done_o`=0, `we_o`=0, `wdata_o`=0.
- **Start acceptance:** `start_i` is sampled at edge E0. After E0: `busy_o`=1, `req_o`=1, `addr_o`=base.
  - After E1: still requesting.
  - After E2: `req_o`=0 and `tx_pin`=0 (start bit of byte 0).
- **Per word:** 2 + 40·`BAUD_DIV` cycles.
- **Whole dump of N words:** N·(2 + 40·`BAUD_DIV`) cycles, plus 10·`BAUD_DIV` cycles if the checksum is enabled.
- **Completion:** `done_o` is asserted in the cycle immediately after the last stop-bit period ends.
- **Zero count:** `word_cnt_i`=0 gives `busy_o`=1 for exactly 1 cycle, then a `done_o` pulse. There is no `req_o` and no TX activity.
- **Start while busy:** `start_i` while `busy_o`=1 is ignored. The latched parameters do not change.
- **Reset mid-dump:** at the next edge all outputs return to their reset values. `tx_pin` goes high even mid-bit, which may truncate a frame. The state returns to IDLE.

## Configuration

- **Macro `UART_DUMP_CKSUM_EN` defined:**
  - An 8-bit XOR accumulator, cleared on start, folds in every transmitted data byte.
  - After the last word, state CKSUM sends the accumulator as one extra 8N1 byte, then `done_o` pulses.
  - A count of 0 sends no checksum.
- **Macro undefined:** no accumulator and no CKSUM state; `done_o` pulses after the last data byte.

## Test plan

- **Single word:** `BAUD_DIV`=4, memory[0x100]=0x4433_2211, start with base 0x100 and count 1.
  - Required: `req_o` high for 2 cycles with `addr_o`=0x100.
  - Required: `tx_pin` decodes to 0x11, 0x22, 0x33, 0x44, each bit exactly 4 cycles.
  - Required: `done_o` at cycle 2+160 after the start edge.
- **Multi-word with unaligned base:** base 0x203, count 3.
  - Required: `addr_o` sequence 0x200, 0x204, 0x208.
  - Required: 12 bytes decoded in little-endian order.
  - Required: `busy_o` high for 3·162 cycles.
- **Zero count and start while busy:**
  - Count 0: `done_o` pulses 1 cycle after start, with `req_o`=0 and `tx_pin`=1 throughout.
  - A second start issued mid-dump: no change to the address sequence or to the total length.
- **Address wrap:** base 0xFFFF_FFFC, count 2. Required: `addr_o` 0xFFFF_FFFC, then 0x0000_0000.
- **Reset mid-dump:** assert `rst` during bit 3 of byte 1.
  - Required next cycle: `tx_pin`=1, `req_o`=0, `busy_o`=0.
  - Required afterwards: a new start runs a full correct dump.
- **Checksum (`UART_DUMP_CKSUM_EN` defined):** words 0x4433_2211 and 0x0000_00FF.
  - Required: a ninth byte of 0xBB (0x11^0x22^0x33^0x44^0xFF).
  - Required: `done_o` at 2·162+40 cycles.
  - With the macro undefined: only 8 bytes are sent.
